// File: rtl/uga_dyna_pkg.sv
// uga_dyna_pkg: shared Dynamixel protocol 1.0 definitions.
//   DYNA_HEADER          preamble byte (0xFF)
//   DYNA_MAX_PARAM       default parameter capacity of a status packet
//   dyna_rx_t            status-packet receive FSM states
//   status_packet_t      decoded status packet (id, length, error, params)
//   dyna_status_checksum checksum a status packet should carry
package uga_dyna_pkg;

  localparam logic [7:0]  DYNA_HEADER    = 8'hFF;
  localparam int unsigned DYNA_MAX_PARAM = 6;

  typedef enum logic [2:0] {
    rx_hdr1,
    rx_hdr2,
    rx_id,
    rx_len,
    rx_error,
    rx_param,
    rx_chk
  } dyna_rx_t;

  typedef struct packed {
    logic [7:0]                     id;
    logic [7:0]                     length;
    logic [7:0]                     error;
    logic [DYNA_MAX_PARAM-1:0][7:0] param;
  } status_packet_t;

  // Sum covers ID, LEN, ERR and the LEN-2 parameter bytes, modulo 256.
  function automatic logic [7:0] dyna_status_checksum(status_packet_t p);
    logic [7:0] sum;
    sum = p.id + p.length + p.error;
    for (int unsigned i = 0; i < DYNA_MAX_PARAM; i++) begin
      if (i + 2 < 32'(p.length)) sum = sum + p.param[i];
    end
    return ~sum;
  endfunction

endpackage

// File: rtl/uga_dyna_status_rx.sv
// uga_dyna_status_rx: receive-side parser for Dynamixel 1.0 status packets
// (FF FF ID LEN ERR PARAM.. CHK) fed from the UART byte stream.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rx_enable        1 = accept bytes; 0 = drop bytes and return to idle
//   rx_data          received byte, valid when rx_data_ready strobes
//   rx_data_ready    one-cycle byte strobe
//   status_valid     one-cycle pulse: good packet published
//   status_id        ID of last good packet
//   status_err       error byte of last good packet
//   status_nparam    parameter count of last good packet
//   status_param     parameters, byte i at [8i+7:8i], unused bytes 0
//   chk_err          one-cycle pulse: checksum mismatch
//   len_err          one-cycle pulse: LEN out of range
//   timeout          one-cycle pulse: inter-byte gap expired mid-packet
//   busy             FSM outside rx_hdr1
module uga_dyna_status_rx
  import uga_dyna_pkg::*;
#(
  parameter int unsigned MAX_PARAM      = DYNA_MAX_PARAM,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rx_enable,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_data_ready,
  output logic                           status_valid,
  output logic [7:0]                     status_id,
  output logic [7:0]                     status_err,
  output logic [$clog2(MAX_PARAM+1)-1:0] status_nparam,
  output logic [8*MAX_PARAM-1:0]         status_param,
  output logic                           chk_err,
  output logic                           len_err,
  output logic                           timeout,
  output logic                           busy
);

  localparam int unsigned NW      = $clog2(MAX_PARAM + 1);
  localparam int unsigned CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  LEN_MAX = 8'(MAX_PARAM + 2);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  dyna_rx_t               state;
  logic [7:0]             sum;
  logic [7:0]             work_id;
  logic [7:0]             work_len;
  logic [7:0]             work_err;
  logic [NW-1:0]          idx;
  logic [8*MAX_PARAM-1:0] work_param;
  logic [CW-1:0]          tcnt;

  assign busy = (state != rx_hdr1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= rx_hdr1;
      sum           <= '0;
      work_id       <= '0;
      work_len      <= '0;
      work_err      <= '0;
      idx           <= '0;
      work_param    <= '0;
      tcnt          <= '0;
      status_valid  <= 1'b0;
      status_id     <= '0;
      status_err    <= '0;
      status_nparam <= '0;
      status_param  <= '0;
      chk_err       <= 1'b0;
      len_err       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      chk_err      <= 1'b0;
      len_err      <= 1'b0;
      timeout      <= 1'b0;

      if (!rx_enable) begin
        // Our own transmission echo: drop silently, keep published fields.
        state <= rx_hdr1;
        tcnt  <= '0;
      end else if (rx_data_ready) begin
        // An accepted byte always restarts the gap counter, so a byte landing
        // on the expiry cycle wins over the timeout.
        tcnt <= '0;
        case (state)
          rx_hdr1: begin
            if (rx_data == DYNA_HEADER) state <= rx_hdr2;
          end
          rx_hdr2: begin
            state <= (rx_data == DYNA_HEADER) ? rx_id : rx_hdr1;
          end
          rx_id: begin
            if (rx_data != DYNA_HEADER) begin
              work_id <= rx_data;
              sum     <= rx_data;
              state   <= rx_len;
            end
          end
          rx_len: begin
            if (rx_data < 8'd2 || rx_data > LEN_MAX) begin
              len_err <= 1'b1;
              state   <= rx_hdr1;
            end else begin
              work_len <= rx_data;
              sum      <= sum + rx_data;
              state    <= rx_error;
            end
          end
          rx_error: begin
            work_err   <= rx_data;
            sum        <= sum + rx_data;
            idx        <= '0;
            work_param <= '0;
            state      <= (work_len == 8'd2) ? rx_chk : rx_param;
          end
          rx_param: begin
            for (int unsigned i = 0; i < MAX_PARAM; i++) begin
              if (idx == NW'(i)) work_param[8*i +: 8] <= rx_data;
            end
            sum <= sum + rx_data;
            idx <= idx + 1'b1;
            if (8'(idx) == work_len - 8'd3) state <= rx_chk;
          end
          rx_chk: begin
            if (rx_data == ~sum) begin
              status_id     <= work_id;
              status_err    <= work_err;
              status_nparam <= NW'(work_len - 8'd2);
              status_param  <= work_param;
              status_valid  <= 1'b1;
            end else begin
              chk_err <= 1'b1;
            end
            state <= rx_hdr1;
          end
          default: state <= rx_hdr1;
        endcase
      end else if (state != rx_hdr1) begin
        if (tcnt == TLAST) begin
          timeout <= 1'b1;
          state   <= rx_hdr1;
          tcnt    <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uga_dyna_status_rx.sv
// tb_uga_dyna_status_rx: directed and randomized bench for uga_dyna_status_rx.
module tb_uga_dyna_status_rx;

  localparam int unsigned MAXP = 6;
  localparam int unsigned TMO  = 40;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                rx_enable;
  logic [7:0]          rx_data;
  logic                rx_data_ready;
  logic                status_valid;
  logic [7:0]          status_id;
  logic [7:0]          status_err;
  logic [2:0]          status_nparam;
  logic [8*MAXP-1:0]   status_param;
  logic                chk_err;
  logic                len_err;
  logic                timeout;
  logic                busy;

  uga_dyna_status_rx #(
    .MAX_PARAM      (MAXP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_enable     (rx_enable),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .status_valid  (status_valid),
    .status_id     (status_id),
    .status_err    (status_err),
    .status_nparam (status_nparam),
    .status_param  (status_param),
    .chk_err       (chk_err),
    .len_err       (len_err),
    .timeout       (timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the last good packet published, and pulse totals.
  logic [7:0] exp_id, exp_err;
  int         exp_n;
  logic [7:0] exp_p [MAXP];
  int exp_valid = 0, exp_chk = 0, exp_len = 0, exp_to = 0;

  // Pulse monitor over the whole run.
  int n_valid = 0, n_chk = 0, n_len = 0, n_to = 0, n_multi = 0;
  always @(negedge clk) begin
    if (status_valid) n_valid++;
    if (chk_err) n_chk++;
    if (len_err) n_len++;
    if (timeout) n_to++;
    if (int'(status_valid) + int'(chk_err) + int'(len_err) + int'(timeout) > 1) n_multi++;
  end

  logic [7:0] pkt [$];
  logic [7:0] p_param [MAXP];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [3:0] pl);
    @(negedge clk);
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    pl = {status_valid, chk_err, len_err, timeout};
    rx_data_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends pkt; pulses must stay low until the last byte, which must give exp_last.
  task automatic send_q(input string tag, input logic [3:0] exp_last, input int max_gap);
    logic [3:0] pl, mid;
    mid = '0;
    for (int i = 0; i < pkt.size(); i++) begin
      if (i != 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(pkt[i], pl);
      if (i != pkt.size() - 1) mid |= pl;
    end
    chk({tag, "_mid_pulses"}, 64'(mid), 64'h0);
    chk({tag, "_last_pulses"}, 64'(pl), 64'(exp_last));
  endtask

  // Status packet for id/err with the first n entries of p_param.
  task automatic build(input logic [7:0] id, input logic [7:0] err, input int n, input bit corrupt);
    int s;
    logic [7:0] c;
    s = int'(id) + n + 2 + int'(err);
    for (int i = 0; i < n; i++) s += int'(p_param[i]);
    c = 8'(255 - (s % 256));
    if (corrupt) c = c ^ 8'($urandom_range(1, 255));
    pkt = {8'hFF, 8'hFF, id, 8'(n + 2), err};
    for (int i = 0; i < n; i++) pkt.push_back(p_param[i]);
    pkt.push_back(c);
  endtask

  task automatic model_good(input logic [7:0] id, input logic [7:0] err, input int n);
    exp_id  = id;
    exp_err = err;
    exp_n   = n;
    for (int i = 0; i < MAXP; i++) exp_p[i] = (i < n) ? p_param[i] : 8'h00;
    exp_valid++;
  endtask

  task automatic check_fields(input string tag);
    logic [8*MAXP-1:0] v;
    for (int i = 0; i < MAXP; i++) v[8*i +: 8] = exp_p[i];
    chk({tag, "_id"}, 64'(status_id), 64'(exp_id));
    chk({tag, "_err"}, 64'(status_err), 64'(exp_err));
    chk({tag, "_nparam"}, 64'(status_nparam), 64'(exp_n));
    chk({tag, "_param"}, 64'(status_param), 64'(v));
  endtask

  initial begin
    logic [3:0] pl;
    logic [7:0] id, err, ln;
    bit         corrupt, anybad;
    int         n, kind;

    rst_n = 1'b0; rx_enable = 1'b1; rx_data = '0; rx_data_ready = 1'b0;
    exp_id = '0; exp_err = '0; exp_n = 0;
    for (int i = 0; i < MAXP; i++) exp_p[i] = '0;
    idle(3);
    chk("reset_pulses_busy", 64'({status_valid, chk_err, len_err, timeout, busy}), 64'h0);
    check_fields("reset");
    @(negedge clk); rst_n = 1'b1;

    // 1: minimal packet
    pkt = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
    send_q("t1", 4'b1000, 0);
    for (int i = 0; i < MAXP; i++) p_param[i] = '0;
    model_good(8'h02, 8'h00, 0);
    check_fields("t1");
    idle(1);
    chk("t1_valid_one_cycle", 64'(status_valid), 64'h0);

    // 2: two params
    pkt = {8'hFF, 8'hFF, 8'h02, 8'h04, 8'h00, 8'h00, 8'h08, 8'hF1};
    send_q("t2", 4'b1000, 0);
    p_param[0] = 8'h00; p_param[1] = 8'h08;
    model_good(8'h02, 8'h00, 2);
    check_fields("t2");

    // 3: bad checksum keeps previous fields
    pkt = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFA};
    send_q("t3", 4'b0100, 0);
    exp_chk++;
    check_fields("t3");

    // 4: extra preamble, then out-of-range LEN
    pkt = {8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h20, 8'hDB};
    send_q("t4", 4'b1000, 0);
    for (int i = 0; i < MAXP; i++) p_param[i] = '0;
    model_good(8'h02, 8'h20, 0);
    check_fields("t4");
    pkt = {8'hFF, 8'hFF, 8'h02, 8'h09};
    send_q("t4_len", 4'b0010, 0);
    exp_len++;
    chk("t4_len_busy", 64'(busy), 64'h0);

    // 5: timeout fires on the TMO-th idle cycle after the last byte
    send_byte(8'hFF, pl); send_byte(8'hFF, pl); send_byte(8'h02, pl);
    anybad = 1'b0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      idle(1);
      if (timeout || !busy) anybad = 1'b1;
    end
    chk("t5_no_early_timeout", 64'(anybad), 64'h0);
    idle(1);
    chk("t5_timeout_busy", 64'({timeout, busy}), 64'b10);
    exp_to++;
    idle(1);
    chk("t5_timeout_one_cycle", 64'(timeout), 64'h0);
    pkt = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
    send_q("t5_after", 4'b1000, 0);
    model_good(8'h02, 8'h00, 0);
    check_fields("t5_after");

    // 5b: byte on the expiry cycle wins
    send_byte(8'hFF, pl); send_byte(8'hFF, pl); send_byte(8'h02, pl);
    idle(int'(TMO) - 1);
    send_byte(8'h02, pl);
    chk("t5b_byte_wins", 64'({pl, busy}), 64'b00001);
    pkt = {8'h00, 8'hFB};
    send_q("t5b_rest", 4'b1000, 0);
    model_good(8'h02, 8'h00, 0);

    // 6: rx_enable low drops a whole packet
    rx_enable = 1'b0;
    pkt = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
    anybad = 1'b0;
    foreach (pkt[i]) begin
      send_byte(pkt[i], pl);
      if (pl != 0 || busy) anybad = 1'b1;
    end
    chk("t6_disabled_quiet", 64'(anybad), 64'h0);
    rx_enable = 1'b1;

    // 6b: enable dropped mid-packet aborts it
    send_byte(8'hFF, pl); send_byte(8'hFF, pl); send_byte(8'h02, pl); send_byte(8'h02, pl);
    @(negedge clk); rx_enable = 1'b0;
    idle(1);
    chk("t6b_abort_busy", 64'(busy), 64'h0);
    rx_enable = 1'b1;
    pkt = {8'h00, 8'hFB};
    send_q("t6b_rest", 4'b0000, 0);
    check_fields("t6b");

    // 6c: asynchronous reset mid-packet
    send_byte(8'hFF, pl); send_byte(8'hFF, pl); send_byte(8'h02, pl);
    chk("t6c_busy_before", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6c_reset_pulses_busy", 64'({status_valid, chk_err, len_err, timeout, busy}), 64'h0);
    exp_id = '0; exp_err = '0; exp_n = 0;
    for (int i = 0; i < MAXP; i++) exp_p[i] = '0;
    check_fields("t6c_reset");
    @(negedge clk); rst_n = 1'b1;

    // Randomized packets, byte gaps well below the timeout
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 7);
      id   = 8'($urandom_range(0, 254));
      if (kind == 0) begin
        ln  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(MAXP + 3, 255));
        pkt = {8'hFF, 8'hFF, id, ln};
        send_q("rand_len", 4'b0010, 3);
        exp_len++;
      end else begin
        n       = $urandom_range(0, MAXP);
        err     = 8'($urandom);
        corrupt = (kind == 1);
        for (int i = 0; i < MAXP; i++) p_param[i] = 8'($urandom);
        build(id, err, n, corrupt);
        send_q(corrupt ? "rand_bad" : "rand_good", corrupt ? 4'b0100 : 4'b1000, 3);
        if (corrupt) exp_chk++;
        else model_good(id, err, n);
      end
      check_fields("rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    idle(2);
    chk("total_valid", 64'(n_valid), 64'(exp_valid));
    chk("total_chk_err", 64'(n_chk), 64'(exp_chk));
    chk("total_len_err", 64'(n_len), 64'(exp_len));
    chk("total_timeout", 64'(n_to), 64'(exp_to));
    chk("pulse_exclusive", 64'(n_multi), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
